// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, reset PC and fetch FSM encoding.
// Imported by the fetch stage and its next-PC selector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack bus between fetch stage and imem.
// master = fetch side, slave = memory side.
interface fetch_unit_if;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemRdata
  );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC mux with branch and jump target adders.
// Priority: jr, then jump, then taken branch, else pc + 4.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [31:0] jr_target,
  input  logic        jr,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        taken;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_tgt   = pc_plus4 + br_off(instr_idx[15:0]);
    jmp_tgt  = {pc_plus4[31:28], instr_idx, 2'b00};
    taken    = (beq & zero) | (bne & ~zero);
  end

  // jr target is word-aligned by masking the low bits
  always_comb begin
    if (jr)
      next_pc = jr_target & 32'hFFFF_FFFC;
    else if (jump)
      next_pc = jmp_tgt;
    else if (taken)
      next_pc = br_tgt;
    else
      next_pc = pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem req/ack FSM, timeout and sticky fault.
// FETCH_ALIGN_CHECK_EN: misaligned jr target faults instead of masking.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic         instrValid,
  output logic [31:0]  pc,
  output logic [31:0]  pcPlus4,
  input  logic         beq,
  input  logic         bne,
  input  logic         jump,
  input  logic         jr,
  input  logic         zero,
  input  logic [31:0]  jrTarget,
  output logic         fault
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_t  state;
  fetch_state_t  state_nx;
  logic [TW-1:0] timer;
  logic [31:0]   next_pc;
  logic          tmo;
  logic          misalign;

  assign tmo = (timer == TW'(TIMEOUT - 1));

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = jr & (jrTarget[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  pc_next_sel u_sel (
    .pc        (pc),
    .instr_idx (instr[25:0]),
    .jr_target (jrTarget),
    .jr        (jr),
    .jump      (jump),
    .beq       (beq),
    .bne       (bne),
    .zero      (zero),
    .pc_plus4  (pcPlus4),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_FETCH;
    else
      state <= state_nx;
  end

  // ack in the timeout cycle still wins
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (imem.imemAck)
          state_nx = S_EXEC;
        else if (tmo)
          state_nx = S_HALT;
      end
      S_EXEC: begin
        if (!stall)
          state_nx = misalign ? S_HALT : S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
    endcase
  end

  // rst_n gating drops the request as soon as reset asserts
  always_comb begin
    imem.imemReq  = rst_n &
      ((state == S_FETCH) | (state == S_WAIT));
    imem.imemAddr = pc;
    instrValid    = (state == S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'd0;
      timer <= '0;
      fault <= 1'b0;
    end else if (state == S_WAIT) begin
      if (imem.imemAck)
        instr <= imem.imemRdata;
      else if (tmo)
        fault <= 1'b1;
      else
        timer <= timer + 1'b1;
    end else if (state == S_EXEC && !stall) begin
      if (misalign) begin
        fault <= 1'b1;
      end else begin
        pc    <= next_pc;
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit with a next-PC model.
// Honors FETCH_ALIGN_CHECK_EN for the misaligned jr case.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        beq = 1'b0;
  logic        bne = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] jrTarget = 32'd0;
  logic        fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .imem       (bus),
    .instr      (instr),
    .instrValid (instrValid),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .beq        (beq),
    .bne        (bne),
    .jump       (jump),
    .jr         (jr),
    .zero       (zero),
    .jrTarget   (jrTarget),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(
    input logic [31:0] cur,
    input logic [31:0] word,
    input logic        c_jr,
    input logic        c_jump,
    input logic        c_beq,
    input logic        c_bne,
    input logic        c_zero,
    input logic [31:0] tgt
  );
    logic [31:0] p4;
    int          off;
    p4  = cur + 32'd4;
    off = $signed(word[15:0]);
    if (c_jr)
      return tgt - (tgt % 4);
    if (c_jump)
      return (p4 & 32'hF000_0000) + (word[25:0] * 4);
    if ((c_beq && c_zero) || (c_bne && !c_zero))
      return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic junk_ctrl();
    jr       = 1'($urandom);
    jump     = 1'($urandom);
    beq      = 1'($urandom);
    bne      = 1'($urandom);
    zero     = 1'($urandom);
    jrTarget = $urandom;
  endtask

  task automatic clr_ctrl();
    {jr, jump, beq, bne, zero} = 5'b0;
    jrTarget = 32'd0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imemReq, 1'b0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_valid", instrValid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    m_pc = 32'd0;
  endtask

  task automatic run_instr(
    input logic [31:0] word,
    input logic        c_jr,
    input logic        c_jump,
    input logic        c_beq,
    input logic        c_bne,
    input logic        c_zero,
    input logic [31:0] tgt,
    input int          dly,
    input int          stalls
  );
    chk("fetch_req", bus.imemReq, 1'b1);
    chk("fetch_addr", bus.imemAddr, m_pc);
    bus.imemAck   = 1'b1;
    bus.imemRdata = ~word;
    junk_ctrl();
    @(posedge clk);
    #1;
    bus.imemAck = 1'b0;
    repeat (dly) begin
      junk_ctrl();
      @(posedge clk);
      #1;
    end
    chk("wait_req", bus.imemReq, 1'b1);
    chk("wait_valid", instrValid, 1'b0);
    bus.imemAck   = 1'b1;
    bus.imemRdata = word;
    @(posedge clk);
    #1;
    bus.imemAck   = 1'b0;
    bus.imemRdata = $urandom;
    chk("exec_valid", instrValid, 1'b1);
    chk("exec_instr", instr, word);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc4", pcPlus4, m_pc + 32'd4);
    jr = c_jr; jump = c_jump; beq = c_beq;
    bne = c_bne; zero = c_zero; jrTarget = tgt;
    stall = 1'b1;
    repeat (stalls) begin
      bus.imemAck   = 1'b1;
      bus.imemRdata = ~word;
      @(posedge clk);
      #1;
      chk("stall_valid", instrValid, 1'b1);
      chk("stall_pc", pc, m_pc);
      chk("stall_instr", instr, word);
    end
    bus.imemAck = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    clr_ctrl();
`ifdef FETCH_ALIGN_CHECK_EN
    if (c_jr && tgt[1:0] != 2'b00) begin
      chk("mis_fault", fault, 1'b1);
      chk("mis_req", bus.imemReq, 1'b0);
      chk("mis_pc", pc, m_pc);
      repeat (2) begin
        bus.imemAck = 1'b1;
        @(posedge clk);
        #1;
      end
      bus.imemAck = 1'b0;
      chk("mis_hold", instrValid, 1'b0);
      reset_pulse();
      return;
    end
`endif
    chk("no_fault", fault, 1'b0);
    m_pc = ref_next(m_pc, word, c_jr, c_jump,
                    c_beq, c_bne, c_zero, tgt);
  endtask

  task automatic timeout_run();
    chk("to_fetch", bus.imemAddr, m_pc);
    @(posedge clk);
    #1;
    repeat (16) begin
      chk("to_req", bus.imemReq, 1'b1);
      chk("to_nofault", fault, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("to_fault", fault, 1'b1);
    chk("to_req0", bus.imemReq, 1'b0);
    chk("to_valid", instrValid, 1'b0);
    bus.imemAck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.imemAck = 1'b0;
    chk("halt_pc", pc, m_pc);
    chk("halt_fault", fault, 1'b1);
    reset_pulse();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] t;
    bus.imemAck   = 1'b0;
    bus.imemRdata = 32'd0;
    m_pc = 32'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_req", bus.imemReq, 1'b0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_valid", instrValid, 1'b0);
    chk("reset_fault", fault, 1'b0);
    chk("reset_instr", instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("first_next", m_pc, 32'h4);
    run_instr(32'h0000_0008, 1, 0, 0, 0, 0, 32'h10, 1, 0);
    run_instr(32'h1000_FFFC, 0, 0, 1, 0, 1, 0, 2, 0);
    run_instr(32'h0000_0008, 1, 0, 0, 0, 0, 32'h10, 0, 0);
    run_instr(32'h1000_FFFC, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0008, 1, 0, 0, 0, 0, 32'h100, 0, 0);
    run_instr(32'h0800_0040, 0, 1, 0, 0, 0, 0, 0, 0);
    run_instr(32'h2008_0001, 0, 0, 0, 0, 0, 0, 0, 3);
    run_instr(32'h0000_0008, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 15, 0);
    run_instr(32'h2008_0001, 0, 0, 0, 0, 0, 0, 0, 1);
    run_instr(32'h1400_0003, 0, 0, 0, 1, 0, 0, 15, 0);

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      t = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      run_instr(w,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                1'($urandom), 1'($urandom), 1'($urandom),
                t, $urandom_range(0, 15), $urandom_range(0, 2));
    end

    chk("midwait_fetch", bus.imemReq, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwait_req", bus.imemReq, 1'b0);
    chk("midwait_pc", pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    m_pc = 32'd0;
    run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0);

    timeout_run();
    run_instr(32'h2008_0002, 0, 0, 0, 0, 0, 0, 3, 0);

    run_instr(32'h0000_0008, 1, 0, 0, 0, 0, 32'h22, 0, 0);
    run_instr(32'h2008_0003, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_jr", bus.imemAddr, m_pc);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
